alu_responder: RTL

Registered, handshaked ALU that is the responding end of the ALU operand/result interface: accepts `operand_a`, `operand_b`, `opcode` from the stimulus side and returns `y`, `carry`, `zero`, `overflow`. It is a two-stage pipeline with valid/ready flow control on both sides. It replaces the purely combinational DUT as the synthesizable target for the class-based bench.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_core.sv | 46 ++++
 rtl/alu_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Purpose: shared types and constants for the ALU responder and its bench.
// Latency: none; this file holds types only.
// Backpressure: none; this file holds types only.
// Contents: alu_op_e opcode enum, alu_res_t result struct, default width/depth, reset result.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_DEPTH = 3;

  typedef enum logic [ALU_DEPTH-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] y;
    logic                 carry;
    logic                 zero;
    logic                 overflow;
  } alu_res_t;

  // An empty output register reads as a zero result, so zero is set.
  localparam alu_res_t ALU_RES_RST = '{y: '0, carry: 1'b0, zero: 1'b1, overflow: 1'b0};

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational ALU datapath, (a, b, op) -> y and flags.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing pipeline decides when the result is captured.
// Ports: a, b operands; op operation select; res result struct (y, carry, zero, overflow).
module alu_core
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  alu_op_e              op,
  output alu_res_t             res
);

  localparam int MSB = ALU_WIDTH - 1;

  // One extra bit catches the carry out of ADD and the borrow out of SUB.
  logic [ALU_WIDTH:0] sum;
  logic [ALU_WIDTH:0] diff;

  always_comb begin
    res  = '0;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    case (op)
      ALU_ADD: begin
        res.y        = sum[MSB:0];
        res.carry    = sum[ALU_WIDTH];
        res.overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        res.y        = diff[MSB:0];
        res.carry    = diff[ALU_WIDTH];
        res.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      ALU_AND: res.y = a & b;
      ALU_OR:  res.y = a | b;
      ALU_XOR: res.y = a ^ b;
      ALU_NOT: res.y = ~a;
      ALU_SHL: {res.carry, res.y} = {a, 1'b0};
      ALU_SHR: {res.y, res.carry} = {1'b0, a};
      default: res.y = '0;
    endcase
    res.zero = (res.y == '0);
  end

endmodule

// File: rtl/alu_responder.sv
// Purpose: two-stage handshaked ALU; S1 registers operands, S2 registers result and flags.
// Latency: 2 cycles, one op per cycle sustained while out_ready is held high.
// Backpressure: buffers two ops when out_ready is low; in_ready follows out_ready the same cycle.
// Ports: clk, rst_n; in_valid/in_ready with operand_a, operand_b, opcode; out_valid/out_ready
//        with y, carry, zero, overflow; ovf_sticky accumulated overflow.
// Build option: define ALU_STICKY_OVF_EN to enable ovf_sticky, otherwise it is tied to 0.
module alu_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = ALU_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [DEPTH-1:0] opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             ovf_sticky
);

  // The opcode space and the result struct are sized by the package.
  if (DEPTH != ALU_DEPTH) begin : g_depth_chk
    $error("alu_responder: DEPTH must be 3");
  end
  if (WIDTH != ALU_WIDTH) begin : g_width_chk
    $error("alu_responder: WIDTH must match alu_pkg::ALU_WIDTH");
  end

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  alu_op_e          s1_op_q, s1_op_d;
  logic             s2_vld_q, s2_vld_d;
  alu_res_t         s2_res_q, s2_res_d;
  alu_res_t         core_res;
  logic             s2_load;
  logic             in_fire;

  alu_core u_core (
    .a   (s1_a_q),
    .b   (s1_b_q),
    .op  (s1_op_q),
    .res (core_res)
  );

  always_comb begin
    // S2 takes S1 whenever its current content is gone by the next edge.
    s2_load  = s1_vld_q && (!s2_vld_q || out_ready);
    // Depends only on state and out_ready, never on in_valid.
    in_ready = !s1_vld_q || s2_load;
    in_fire  = in_valid && in_ready;

    s1_vld_d = in_fire || (s1_vld_q && !s2_load);
    s1_a_d   = in_fire ? operand_a : s1_a_q;
    s1_b_d   = in_fire ? operand_b : s1_b_q;
    s1_op_d  = in_fire ? alu_op_e'(opcode) : s1_op_q;

    s2_vld_d = s2_load || (s2_vld_q && !out_ready);
    s2_res_d = s2_load ? core_res : s2_res_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_op_q  <= ALU_ADD;
      s2_vld_q <= 1'b0;
      s2_res_q <= ALU_RES_RST;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_op_q  <= s1_op_d;
      s2_vld_q <= s2_vld_d;
      s2_res_q <= s2_res_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign y         = s2_res_q.y;
  assign carry     = s2_res_q.carry;
  assign zero      = s2_res_q.zero;
  assign overflow  = s2_res_q.overflow;

`ifdef ALU_STICKY_OVF_EN
  logic ovf_sticky_q, ovf_sticky_d;

  // Only results actually handed to the consumer count.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q || (s2_vld_q && out_ready && s2_res_q.overflow);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
`else
  assign ovf_sticky = 1'b0;
`endif

endmodule
